// File: rtl/fetch_packet_decoder_if.sv
// Fetch-window / decode / redirect bundle between fetch and the packet decoder.
// Stat ports exist only when FETCH_DECODER_STATS_EN is defined.
interface fetch_packet_decoder_if;
  logic [31:0] fetchoutput;
  logic [19:0] previous_programcounter;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;
  logic        flush;
  logic [31:0] dec_instr;
  logic        dec_valid;
  logic        dec_is32;
  logic        dec_illegal;
  logic        link_valid;
  logic [19:0] link_addr;
`ifdef FETCH_DECODER_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_bubbles;
  logic [15:0] stat_redirects;

  modport master (
    output fetchoutput, previous_programcounter,
    input  pcjumpenable, pcchange, pclocation, flush,
    input  dec_instr, dec_valid, dec_is32, dec_illegal,
    input  link_valid, link_addr,
    input  stat_issued, stat_bubbles, stat_redirects
  );
  modport slave (
    input  fetchoutput, previous_programcounter,
    output pcjumpenable, pcchange, pclocation, flush,
    output dec_instr, dec_valid, dec_is32, dec_illegal,
    output link_valid, link_addr,
    output stat_issued, stat_bubbles, stat_redirects
  );
`else
  modport master (
    output fetchoutput, previous_programcounter,
    input  pcjumpenable, pcchange, pclocation, flush,
    input  dec_instr, dec_valid, dec_is32, dec_illegal,
    input  link_valid, link_addr
  );
  modport slave (
    input  fetchoutput, previous_programcounter,
    output pcjumpenable, pcchange, pclocation, flush,
    output dec_instr, dec_valid, dec_is32, dec_illegal,
    output link_valid, link_addr
  );
`endif
endinterface

// File: rtl/fetch_packet_decoder.sv
// Decode-side consumer of the fetch window; issues instrs, drives redirects.
// Optional counters: define FETCH_DECODER_STATS_EN.
module fetch_packet_decoder #(
  parameter int REDIRECT_CYCLES = 2
) (
  input logic                    clock,
  input logic                    reset,
  fetch_packet_decoder_if.slave  fp
);

  typedef enum logic [1:0] {
    RUN,
    SKIP,
    REDIRECT
  } state_t;

  typedef struct packed {
    logic [2:0]  pje;
    logic [8:0]  chg;
    logic [5:0]  loc;
    logic        flush;
    logic [31:0] instr;
    logic        valid;
    logic        is32;
    logic        ill;
    logic        lv;
    logic [19:0] la;
  } out_t;

  localparam logic [2:0] CNT_INIT = 3'(REDIRECT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  out_t        q, d;

  logic [15:0] older, newer;
  logic [2:0]  op;
  logic        is_bubble, is_branch;
  logic        is_16, is_32, is_ill;

  assign older = fp.fetchoutput[31:16];
  assign newer = fp.fetchoutput[15:0];
  assign op    = older[12:10];

  // Exactly one of these five classes holds for any older word.
  assign is_bubble = (older[15:1] == 15'd0);
  assign is_branch = ~older[15] & (older[14:13] == 2'b10) & ~op[2];
  assign is_16     = ~older[15] & ~is_bubble & ~is_branch;
  assign is_32     = older[15] & newer[15];
  assign is_ill    = older[15] & ~newer[15];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d         = '0;
    d.pje     = q.pje;
    d.chg     = q.chg;
    d.loc     = q.loc;
    d.la      = q.la;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          is_bubble: ;
          is_branch: begin
            d.valid   = 1'b1;
            d.instr   = {older, 16'h0000};
            d.flush   = 1'b1;
            state_nxt = REDIRECT;
            cnt_nxt   = CNT_INIT;
            unique case (op[1:0])
              2'b00: begin
                d.pje = 3'd1;
                d.chg = older[8:0];
                d.loc = '0;
              end
              2'b01: begin
                d.pje = 3'd4;
                d.chg = older[8:0];
                d.loc = '0;
              end
              2'b10: begin
                d.pje = 3'd2;
                d.chg = '0;
                d.loc = older[5:0];
              end
              2'b11: begin
                d.pje = 3'd3;
                d.chg = '0;
                d.loc = older[5:0];
              end
            endcase
            if (op[0]) begin
              d.lv = 1'b1;
              d.la = fp.previous_programcounter + 20'd1;
            end
          end
          is_16: begin
            d.valid = 1'b1;
            d.instr = {older, 16'h0000};
          end
          is_32: begin
            d.valid   = 1'b1;
            d.is32    = 1'b1;
            d.instr   = fp.fetchoutput;
            state_nxt = SKIP;
          end
          is_ill: d.ill = 1'b1;
        endcase
      end
      SKIP: state_nxt = RUN;
      REDIRECT: begin
        cnt_nxt = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        if (cnt == 3'd0) begin
          d.pje     = '0;
          d.chg     = '0;
          d.loc     = '0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign fp.pcjumpenable = q.pje;
  assign fp.pcchange     = q.chg;
  assign fp.pclocation   = q.loc;
  assign fp.flush        = q.flush;
  assign fp.dec_instr    = q.instr;
  assign fp.dec_valid    = q.valid;
  assign fp.dec_is32     = q.is32;
  assign fp.dec_illegal  = q.ill;
  assign fp.link_valid   = q.lv;
  assign fp.link_addr    = q.la;

`ifdef FETCH_DECODER_STATS_EN
  logic [15:0] n_iss, n_bub, n_red;
  logic        bub_ev, red_ev;

  assign bub_ev = (state == RUN) & is_bubble;
  assign red_ev = (state == RUN) & is_branch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_iss <= '0;
      n_bub <= '0;
      n_red <= '0;
    end else begin
      if (d.valid && n_iss != 16'hFFFF) n_iss <= n_iss + 16'd1;
      if (bub_ev && n_bub != 16'hFFFF) n_bub <= n_bub + 16'd1;
      if (red_ev && n_red != 16'hFFFF) n_red <= n_red + 16'd1;
    end
  end

  assign fp.stat_issued    = n_iss;
  assign fp.stat_bubbles   = n_bub;
  assign fp.stat_redirects = n_red;
`endif

endmodule
